// File: rtl/fc_result_reader_pkg.sv
// fc_result_reader_pkg: shared FSM states and SRAM lane ordering for the FC result reader
package fc_result_reader_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fc_state_t;
  localparam bit LANE0_MSB = 1'b1;
  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return (LANE0_MSB ? lanes - 1 - lane : lane) * width;
  endfunction
endpackage

// File: rtl/fc_result_reader_argmax4.sv
// argmax4: folds one word of signed lanes into a running max/index, ties keep the lower index
module argmax4
  import fc_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic [LANES*DATA_WIDTH-1:0]   word,
  input  logic [LANES-1:0]              lane_valid,
  input  logic [3:0]                    base_idx,
  input  logic signed [DATA_WIDTH-1:0]  in_max,
  input  logic [3:0]                    in_idx,
  output logic signed [DATA_WIDTH-1:0]  out_max,
  output logic [3:0]                    out_idx
);
  always_comb begin
    out_max = in_max;
    out_idx = in_idx;
    for (int l = 0; l < LANES; l++) begin
      if (lane_valid[l] && $signed(word[lane_lsb(l, LANES, DATA_WIDTH) +: DATA_WIDTH]) > out_max) begin
        out_max = $signed(word[lane_lsb(l, LANES, DATA_WIDTH) +: DATA_WIDTH]);
        out_idx = base_idx + 4'(l);
      end
    end
  end
endmodule

// File: rtl/fc_result_reader.sv
// fc_result_reader: scans FC2 scores from SRAM f and hands out the argmax class and score
module fc_result_reader
  import fc_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int CLASS_NUM = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                                         clk,
  input  logic                                         srstn,
  input  logic                                         fc2_done,
  output logic [9:0]                                   sram_raddr_f,
  input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
  output logic                                         busy,
  output logic                                         result_valid,
  input  logic                                         result_ready,
  output logic [3:0]                                   result_class,
  output logic signed [DATA_WIDTH-1:0]                 result_score
);
  localparam int N = DATA_NUM_PER_SRAM_ADDR;
  localparam int NWORDS = (CLASS_NUM + N - 1) / N;
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  fc_state_t state, next;
  logic [9:0] cnt, fold_word;
  logic fold;
  logic [N-1:0] lane_valid;
  logic [3:0] base_idx, run_idx, nidx;
  logic signed [DATA_WIDTH-1:0] run_max, nmax;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = fc2_done ? FETCH : IDLE;
      FETCH: next = (cnt == 10'(NWORDS - 1)) ? DRAIN : FETCH;
      DRAIN: next = DONE;
      DONE:  next = result_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  // data arrives a cycle after its address, so each fold consumes the previous word
  always_comb begin
    fold = (state == FETCH && cnt != 10'd0) || state == DRAIN;
    fold_word = (state == DRAIN) ? 10'(NWORDS - 1) : cnt - 10'd1;
    base_idx = 4'(32'(fold_word) * N);
    for (int l = 0; l < N; l++) lane_valid[l] = (32'(fold_word) * N + l) < CLASS_NUM;
  end
  assign sram_raddr_f = 10'(BASE_ADDR) + ((state == FETCH) ? cnt : 10'd0);
  assign busy = state != IDLE;
  assign result_valid = state == DONE;
  argmax4 #(.DATA_WIDTH(DATA_WIDTH), .LANES(N)) u_argmax4 (
    .word(sram_rdata_f), .lane_valid(lane_valid), .base_idx(base_idx),
    .in_max(run_max), .in_idx(run_idx), .out_max(nmax), .out_idx(nidx)
  );
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state <= IDLE;
      cnt <= 10'd0;
      run_max <= SMIN;
      run_idx <= 4'd0;
      result_class <= 4'd0;
      result_score <= '0;
    end else begin
      state <= next;
      cnt <= (state == FETCH) ? cnt + 10'd1 : 10'd0;
      if (state == IDLE && fc2_done) begin
        run_max <= SMIN;
        run_idx <= 4'd0;
      end else if (fold) begin
        run_max <= nmax;
        run_idx <= nidx;
      end
      if (state == DRAIN) begin
        result_class <= nidx;
        result_score <= nmax;
      end
    end
  end
endmodule

// File: tb/tb_fc_result_reader.sv
// tb_fc_result_reader: randomized scenario bench against a plain argmax reference model
module tb_fc_result_reader;
  logic clk = 1'b0, srstn = 1'b0, fc2_done = 1'b0, result_ready = 1'b0;
  logic [9:0] sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic busy, result_valid;
  logic [3:0] result_class;
  logic signed [7:0] result_score;
  logic [31:0] mem [0:1023];
  int sc[10];
  int pad;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

  fc_result_reader dut (
    .clk(clk), .srstn(srstn), .fc2_done(fc2_done), .sram_raddr_f(sram_raddr_f),
    .sram_rdata_f(sram_rdata_f), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_class(result_class), .result_score(result_score)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < 12; i++) begin
      int v;
      v = (i < 10) ? sc[i] : pad;
      mem[i/4][(3 - i%4)*8 +: 8] = 8'(v);
    end
  endtask

  function automatic void model(output int cls, output int score);
    score = -128;
    cls = 0;
    for (int i = 0; i < 10; i++)
      if (sc[i] > score) begin
        score = sc[i];
        cls = i;
      end
  endfunction

  task automatic launch(output int lat);
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    lat = 1;
    while (!result_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    tick();
    tick();
    n_checks += 5;
    if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", result_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (result_class !== 4'd0) begin n_fail++; $display("FAIL reset_class got %0d expected 0", result_class); end
    if (result_score !== 8'sd0) begin n_fail++; $display("FAIL reset_score got %0d expected 0", result_score); end
    if (sram_raddr_f !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d expected 0", sram_raddr_f); end
    srstn = 1'b1;
    tick();
  endtask

  task automatic test_example();
    int lat;
    sc = '{3, -1, 7, 2, 0, 5, -8, 1, 6, 4};
    pad = 0;
    load();
    launch(lat);
    n_checks += 7;
    if (lat !== 5) begin n_fail++; $display("FAIL example_latency got %0d expected 5", lat); end
    if (result_class !== 4'd2) begin n_fail++; $display("FAIL example_class got %0d expected 2", result_class); end
    if (int'(result_score) !== 7) begin n_fail++; $display("FAIL example_score got %0d expected 7", result_score); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL example_busy got %b expected 1", busy); end
    accept();
    if (busy !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL example_idle got busy=%b valid=%b expected 0 0", busy, result_valid); end
    tick();
    if (result_class !== 4'd2) begin n_fail++; $display("FAIL example_hold_class got %0d expected 2", result_class); end
    if (int'(result_score) !== 7) begin n_fail++; $display("FAIL example_hold_score got %0d expected 7", result_score); end
  endtask

  task automatic test_all_min();
    int lat;
    foreach (sc[i]) sc[i] = -128;
    pad = -128;
    load();
    launch(lat);
    n_checks += 2;
    if (result_class !== 4'd0) begin n_fail++; $display("FAIL allmin_class got %0d expected 0", result_class); end
    if (int'(result_score) !== -128) begin n_fail++; $display("FAIL allmin_score got %0d expected -128", result_score); end
    accept();
  endtask

  task automatic test_padding();
    int lat;
    foreach (sc[i]) sc[i] = int'($urandom_range(0, 227)) - 128;
    sc[9] = 100;
    pad = 127;
    load();
    launch(lat);
    n_checks += 2;
    if (result_class !== 4'd9) begin n_fail++; $display("FAIL padding_class got %0d expected 9", result_class); end
    if (int'(result_score) !== 100) begin n_fail++; $display("FAIL padding_score got %0d expected 100", result_score); end
    accept();
  endtask

  task automatic test_stall();
    int lat, ec, es, bad;
    foreach (sc[i]) sc[i] = int'($urandom_range(0, 255)) - 128;
    pad = int'($urandom_range(0, 255)) - 128;
    load();
    model(ec, es);
    launch(lat);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      fc2_done = (k == 3);
      tick();
      if (result_valid !== 1'b1 || busy !== 1'b1 || int'(result_class) !== ec || int'(result_score) !== es) bad++;
    end
    fc2_done = 1'b0;
    n_checks += 3;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_stable got %0d unstable cycles expected 0", bad); end
    accept();
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle_busy got %b expected 0", busy); end
    tick();
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_ignored_start got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, ec, es;
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    tick();
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    n_checks += 6;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_state got busy=%b valid=%b expected 0 0", busy, result_valid); end
    if (result_class !== 4'd0) begin n_fail++; $display("FAIL midreset_class got %0d expected 0", result_class); end
    if (result_score !== 8'sd0) begin n_fail++; $display("FAIL midreset_score got %0d expected 0", result_score); end
    if (sram_raddr_f !== 10'd0) begin n_fail++; $display("FAIL midreset_addr got %0d expected 0", sram_raddr_f); end
    foreach (sc[i]) sc[i] = int'($urandom_range(0, 255)) - 128;
    pad = 127;
    load();
    model(ec, es);
    launch(lat);
    if (int'(result_class) !== ec) begin n_fail++; $display("FAIL midreset_rerun_class got %0d expected %0d", result_class, ec); end
    if (int'(result_score) !== es) begin n_fail++; $display("FAIL midreset_rerun_score got %0d expected %0d", result_score, es); end
    accept();
  endtask

  task automatic test_back_to_back();
    int lat;
    foreach (sc[i]) sc[i] = 5;
    sc[7] = 6;
    pad = 0;
    load();
    launch(lat);
    n_checks += 3;
    if (result_class !== 4'd7) begin n_fail++; $display("FAIL b2b_first_class got %0d expected 7", result_class); end
    accept();
    foreach (sc[i]) sc[i] = 5;
    sc[4] = 9;
    load();
    launch(lat);
    if (result_class !== 4'd4) begin n_fail++; $display("FAIL b2b_second_class got %0d expected 4", result_class); end
    if (lat !== 5) begin n_fail++; $display("FAIL b2b_second_latency got %0d expected 5", lat); end
    accept();
  endtask

  task automatic test_random();
    int lat, ec, es;
    for (int it = 0; it < 20; it++) begin
      foreach (sc[i]) sc[i] = int'($urandom_range(0, 255)) - 128;
      if (it % 4 == 0) sc[$urandom_range(0, 9)] = sc[$urandom_range(0, 9)];
      pad = int'($urandom_range(0, 255)) - 128;
      load();
      model(ec, es);
      launch(lat);
      n_checks += 3;
      if (lat !== 5) begin n_fail++; $display("FAIL random_latency it=%0d got %0d expected 5", it, lat); end
      if (int'(result_class) !== ec) begin n_fail++; $display("FAIL random_class it=%0d got %0d expected %0d", it, result_class, ec); end
      if (int'(result_score) !== es) begin n_fail++; $display("FAIL random_score it=%0d got %0d expected %0d", it, result_score, es); end
      repeat ($urandom_range(0, 3)) tick();
      accept();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    test_reset();
    test_example();
    test_all_min();
    test_padding();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
